// File: rtl/join_any_pkg.sv
// Shared types and sizing for the registered 1-to-8 demultiplexer.
package join_any_pkg;

    localparam int WIDTH     = 8;
    localparam int NUM_PORTS = 8;
    localparam int SEL_W     = 4;
    localparam int PORT_W    = $clog2(NUM_PORTS);

    typedef logic [WIDTH-1:0] data_t;
    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [PORT_W-1:0] {
        PORT_A, PORT_B, PORT_C, PORT_D,
        PORT_E, PORT_F, PORT_G, PORT_H
    } port_e;

endpackage

// File: rtl/join_any_sel_decode.sv
// Select decoder: turns sel_i into a one-hot port enable plus an invalid flag.
// An out-of-range select yields an all-zero one-hot so no port is enabled.
module join_any_sel_decode
    import join_any_pkg::*;
(
    input  sel_t                 sel_i,
    output logic [NUM_PORTS-1:0] onehot_o,
    output logic                 invalid_o
);

    // Decode the select; defaults first so every path assigns both outputs.
    // NOTE: assigning defaults at the top of always_comb is what prevents latch inference.
    always_comb begin
        onehot_o  = '0;
        invalid_o = (sel_i >= sel_t'(NUM_PORTS));
        if (!invalid_o) begin
            onehot_o[sel_i[PORT_W-1:0]] = 1'b1;
        end
    end

endmodule

// File: rtl/join_any_demux.sv
// Registered 1-to-8 demultiplexer. value_i is gated onto the port picked by
// sel_i and captured in a register bank; every other port registers zero.
// All outputs come straight from flops, so there is no input-to-output path.
module join_any_demux
    import join_any_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,      // asynchronous, active-low
    input  data_t       value_i,
    input  sel_t        sel_i,
    output data_t       a_o,
    output data_t       b_o,
    output data_t       c_o,
    output data_t       d_o,
    output data_t       e_o,
    output data_t       f_o,
    output data_t       g_o,
    output data_t       h_o,
    output logic        sel_err_o
);

    logic [NUM_PORTS-1:0] onehot;
    logic                 invalid;
    data_t                port_d [NUM_PORTS];
    data_t                port_q [NUM_PORTS];
    logic                 sel_err_q;

    join_any_sel_decode u_decode (
        .sel_i     (sel_i),
        .onehot_o  (onehot),
        .invalid_o (invalid)
    );

    // Gate the data word onto the selected port only; the rest get zero.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            port_d[k] = value_i & {WIDTH{onehot[k]}};
        end
    end

    // Output register bank and select-error flag.
    // NOTE: this is a small set of output flops, not a memory, so every entry is reset;
    //       non-blocking assignments keep all flops sampling the same pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                port_q[k] <= '0;
            end
            sel_err_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                port_q[k] <= port_d[k];
            end
            sel_err_q <= invalid;
        end
    end

    assign a_o       = port_q[PORT_A];
    assign b_o       = port_q[PORT_B];
    assign c_o       = port_q[PORT_C];
    assign d_o       = port_q[PORT_D];
    assign e_o       = port_q[PORT_E];
    assign f_o       = port_q[PORT_F];
    assign g_o       = port_q[PORT_G];
    assign h_o       = port_q[PORT_H];
    assign sel_err_o = sel_err_q;

endmodule

// File: tb/tb_join_any_demux.sv
// Self-checking bench for join_any_demux: a table of directed vectors, random
// and ramp stimulus against a behavioural model, and hand-written reset sequences.
module tb_join_any_demux;
    import join_any_pkg::*;

    logic  clk_i;
    logic  rst_i;
    data_t value_i;
    sel_t  sel_i;
    data_t a_o, b_o, c_o, d_o, e_o, f_o, g_o, h_o;
    logic  sel_err_o;

    int checks;
    int errors;

    join_any_demux dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .value_i   (value_i),
        .sel_i     (sel_i),
        .a_o       (a_o),
        .b_o       (b_o),
        .c_o       (c_o),
        .d_o       (d_o),
        .e_o       (e_o),
        .f_o       (f_o),
        .g_o       (g_o),
        .h_o       (h_o),
        .sel_err_o (sel_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Directed vector record: inputs plus the port expected to carry the data
    // (8 = no port) and the expected error flag.
    typedef struct {
        sel_t  sel;
        data_t val;
        int    exp_port;
        logic  exp_err;
    } vec_t;

    vec_t vecs[$];

    // Snapshot of all outputs: {sel_err, h, g, f, e, d, c, b, a}.
    function automatic logic [64:0] outs();
        return {sel_err_o, h_o, g_o, f_o, e_o, d_o, c_o, b_o, a_o};
    endfunction

    // Build an expected snapshot from "which port carries what".
    function automatic logic [64:0] build(input int port, input data_t v, input logic err);
        logic [64:0] r;
        r = '0;
        if (port >= 0 && port < 8) r[port*8 +: 8] = v;
        r[64] = err;
        return r;
    endfunction

    // Behavioural reference: the selected port shows the value if the select
    // names one of the eight ports; otherwise nothing, and the error flag is set.
    function automatic logic [64:0] model(input sel_t s, input data_t v);
        int idx;
        idx = int'(s);
        if (idx < NUM_PORTS) return build(idx, v, 1'b0);
        return build(-1, v, 1'b1);
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic step(input sel_t s, input data_t v);
        sel_i   = s;
        value_i = v;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // ---- Reset with clocks running and live inputs ----
        rst_i   = 1'b0;
        value_i = 8'hFF;
        sel_i   = 4'd3;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_hold", outs(), '0);

        // Release between edges: nothing changes until the next rising edge.
        rst_i = 1'b1;
        #2;
        check("release_no_change", outs(), '0);
        @(posedge clk_i);
        #1;
        check("first_edge_after_reset", outs(), build(3, 8'hFF, 1'b0));

        // Assert reset between edges: outputs clear immediately.
        #3;
        rst_i = 1'b0;
        #1;
        check("async_reset_between_edges", outs(), '0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // ---- Table-driven directed vectors ----
        for (int k = 0; k < 8; k++) vecs.push_back('{sel_t'(k), 8'hA5, k, 1'b0});
        vecs.push_back('{4'd8,  8'h1F, 8, 1'b1});
        vecs.push_back('{4'd2,  8'h1F, 2, 1'b0});
        vecs.push_back('{4'd15, 8'hFF, 8, 1'b1});
        vecs.push_back('{4'd5,  8'h00, 5, 1'b0});
        vecs.push_back('{4'd7,  8'h80, 7, 1'b0});
        vecs.push_back('{4'd7,  8'h01, 7, 1'b0});
        vecs.push_back('{4'd0,  8'h01, 0, 1'b0});
        vecs.push_back('{4'd9,  8'h55, 8, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].sel, vecs[i].val);
            check($sformatf("vec%0d_sel%0d", i, vecs[i].sel), outs(),
                  build(vecs[i].exp_port, vecs[i].val, vecs[i].exp_err));
        end

        // ---- Ramp: value 0..31 with random select 0..8 ----
        for (int v = 0; v < 32; v++) begin
            sel_t s;
            s = sel_t'($urandom_range(0, 8));
            step(s, data_t'(v));
            check($sformatf("ramp_v%0d_sel%0d", v, s), outs(), model(s, data_t'(v)));
        end

        // ---- Random: full select range, random data ----
        for (int i = 0; i < 200; i++) begin
            sel_t  s;
            data_t v;
            s = sel_t'($urandom_range(0, 15));
            v = data_t'($urandom);
            step(s, v);
            check($sformatf("rand%0d_sel%0d", i, s), outs(), model(s, v));
        end

        // ---- Reset mid-stream ----
        step(4'd7, 8'h3C);
        check("midstream_before", outs(), build(7, 8'h3C, 1'b0));
        step(4'd7, 8'h3C);
        #3;
        rst_i = 1'b0;
        #1;
        check("midstream_reset_immediate", outs(), '0);
        @(posedge clk_i);
        #1;
        check("midstream_reset_held", outs(), '0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("midstream_first_edge", outs(), build(7, 8'h3C, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
